pc_fetch_ctrl: RTL and testbench

//   Program-counter and fetch sequencer for the single-clock core. It holds the PC and fetches each

---
 rtl/pc_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and instruction fetch sequencer.
// The block fetches one instruction from imem with a req/ack handshake and
// presents it to the datapath for exactly one execute cycle. On the edge that
// leaves execute, it picks the next PC from the JALR/JAL/branch decisions.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | first cycle after reset release; no request is issued yet
//   S_FETCH | imem_req high at pc; waits as long as needed for imem_ack
//   S_EXEC  | instr_valid high; the next PC is chosen and loaded on exit
//   S_HALT  | fetching stopped; fetch resumes at the updated pc when halt=0
module pc_fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_PC  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            B_type_jump_flag,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] jalr_base,
  input  logic            halt,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_trap
);

  localparam logic [31:0]     NOP_INSTR     = 32'h0000_0013;
  localparam logic [XLEN-1:0] CLEAR_BIT0    = {{(XLEN-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] branch_tgt;
  logic [XLEN-1:0] next_tgt;
  logic            tgt_misalign;

  // Next-PC candidates and priority select; JALR beats JAL beats branch.
  always_comb begin
    pc_plus4     = pc_q + XLEN'(4);
    jalr_sum     = jalr_base + imm;
    branch_tgt   = pc_q + imm;
    next_tgt     = pc_plus4;
    if (jalr) begin
      next_tgt = jalr_sum & CLEAR_BIT0;
    end else if (jal || B_type_jump_flag) begin
      next_tgt = branch_tgt;
    end
    // Only bit 1 matters: bit 0 is cleared for JALR and tolerated otherwise.
    tgt_misalign = next_tgt[1];
  end

  // Sequencer next-state, PC/instruction updates and handshake outputs.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    imem_req      = 1'b0;
    imem_addr     = '0;
    instr_valid   = 1'b0;
    misalign_trap = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid   = 1'b1;
        misalign_trap = tgt_misalign;
        pc_d          = tgt_misalign ? TRAP_PC : next_tgt;
        state_d       = halt ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (!halt) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC and instruction registers; reset aborts any fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed reset/handshake sequences, a table of
// next-PC vectors, and randomized instruction streams against a
// per-instruction reference model of the next-PC rules.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        br = 1'b0;
  logic        jal = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] jalr_base = '0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_trap;

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .B_type_jump_flag(br), .jal(jal), .jalr(jalr),
    .imm(imm), .jalr_base(jalr_base), .halt(halt),
    .pc(pc), .pc_plus4(pc_plus4), .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] start_pc;
    logic        jr;
    logic        jl;
    logic        b;
    logic [31:0] im;
    logic [31:0] bs;
    logic [31:0] exp_next;
    logic        exp_trap;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    if (!imem_req) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: imem_req stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  // Complete one fetch at addr with dly ack-wait cycles; ends sampled in EXEC.
  task automatic fetch(input logic [31:0] addr, input int dly, input logic [31:0] word);
    wait_req();
    chk("fetch_addr", imem_addr, addr);
    imem_ack = 1'b0;
    for (int d = 0; d < dly; d++) begin
      tick();
      chk("wait_req_held", imem_req, 1);
      chk("wait_addr_held", imem_addr, addr);
      chk("wait_no_valid", instr_valid, 0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("instr_capture", instr, word);
  endtask

  // Drive control inputs during EXEC, check it, then leave EXEC.
  task automatic do_exec(input logic jr, input logic jl, input logic b,
                         input logic [31:0] im, input logic [31:0] bs,
                         input logic exp_trap, input logic [31:0] exp_pc);
    chk("exec_valid", instr_valid, 1);
    chk("exec_pc", pc, exp_pc);
    chk("exec_pc_plus4", pc_plus4, exp_pc + 32'd4);
    jalr = jr; jal = jl; br = b; imm = im; jalr_base = bs;
    imem_ack = 1'($urandom_range(0, 1));
    #1;
    chk("exec_trap", misalign_trap, exp_trap);
    tick();
    jalr = 0; jal = 0; br = 0; imm = $urandom; jalr_base = $urandom;
    imem_ack = 1'b0;
    chk("post_exec_valid", instr_valid, 0);
    chk("post_exec_trap", misalign_trap, 0);
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic jr,
                                             input logic jl, input logic b,
                                             input logic [31:0] im, input logic [31:0] bs,
                                             output logic trap);
    logic [31:0] t;
    if (jr)           t = (bs + im) & 32'hFFFF_FFFE;
    else if (jl || b) t = cur + im;
    else              t = cur + 32'd4;
    trap = t[1];
    return trap ? TRAP_PC : t;
  endfunction

  initial begin
    logic [31:0] cur;
    logic [31:0] nxt;
    logic        trp;
    logic        r_jr, r_jl, r_b;
    logic [31:0] r_im, r_bs, r_word;
    int          hold;

    vecs[0] = '{32'h40, 0, 0, 1, 32'hFFFF_FFF0, 32'h0, 32'h30, 0};
    vecs[1] = '{32'h40, 0, 0, 0, 32'hFFFF_FFF0, 32'h0, 32'h44, 0};
    vecs[2] = '{32'h44, 1, 1, 0, 32'h10, 32'h1001, 32'h1010, 0};
    vecs[3] = '{32'h1010, 0, 1, 0, 32'h6, 32'h0, TRAP_PC, 1};
    vecs[4] = '{32'hFFFF_FFFC, 0, 0, 0, 32'h8, 32'h0, 32'h0, 0};
    vecs[5] = '{32'h200, 0, 1, 1, 32'h20, 32'h0, 32'h220, 0};
    vecs[6] = '{32'h300, 1, 0, 0, 32'h0, 32'h2, TRAP_PC, 1};
    vecs[7] = '{32'h80, 0, 0, 1, 32'hFFFF_FF80, 32'h0, 32'h0, 0};
    vecs[8] = '{32'h10, 1, 0, 1, 32'hFFFF_FFDD, 32'h123, 32'h100, 0};
    vecs[9] = '{32'h500, 0, 0, 0, 32'h1000, 32'h0, 32'h504, 0};

    // Reset state
    tick();
    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_trap", misalign_trap, 0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, NOP);

    // Ack in the same cycle as each request: dead cycle, then 2 cycles/instr
    imem_ack = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t1_req", imem_req, (k % 2 == 1) ? 1 : 0);
      chk("t1_addr", imem_addr, (k % 2 == 1) ? 32'((k / 2) * 4) : 32'h0);
      chk("t1_valid", instr_valid, (k > 0 && k % 2 == 0) ? 1 : 0);
      if (k > 0 && k % 2 == 0) chk("t1_instr", instr, 32'hA000_0000 | 32'(k - 1));
      imem_rdata = 32'hA000_0000 | 32'(k);
      if (k < 5) tick();
    end
    imem_ack = 1'b0;

    // Ack delayed by 3 cycles
    fetch(32'h8, 3, 32'h1234_5678);
    do_exec(0, 0, 0, 32'h0, 32'h0, 0, 32'h8);
    cur = 32'hC;

    // Table of next-PC vectors, each started via a JALR to its start pc
    for (int i = 0; i < 10; i++) begin
      fetch(cur, 0, 32'h0000_0067);
      do_exec(1, 0, 0, 32'h0, vecs[i].start_pc, 0, cur);
      fetch(vecs[i].start_pc, i % 3, 32'hC0DE_0000 | 32'(i));
      do_exec(vecs[i].jr, vecs[i].jl, vecs[i].b, vecs[i].im, vecs[i].bs,
              vecs[i].exp_trap, vecs[i].start_pc);
      cur = vecs[i].exp_next;
    end

    // halt raised during FETCH: instruction still executes, then HALT
    halt = 1'b1;
    fetch(cur, 2, 32'h0BAD_F00D);
    do_exec(0, 0, 0, 32'h0, 32'h0, 0, cur);
    cur = cur + 32'd4;
    for (int h = 0; h < 4; h++) begin
      chk("halt_req", imem_req, 0);
      chk("halt_valid", instr_valid, 0);
      chk("halt_pc", pc, cur);
      imem_ack = 1'b1; jal = 1'b1; imm = 32'h40;
      tick();
    end
    imem_ack = 1'b0; jal = 1'b0; halt = 1'b0;
    tick();
    fetch(cur, 0, 32'h1111_2222);
    do_exec(0, 0, 0, 32'h0, 32'h0, 0, cur);
    cur = cur + 32'd4;

    // Randomized instruction stream against the reference model
    for (int n = 0; n < 200; n++) begin
      r_word = $urandom;
      fetch(cur, $urandom_range(0, 3), r_word);
      r_jr = ($urandom_range(0, 3) == 0);
      r_jl = ($urandom_range(0, 3) == 0);
      r_b  = ($urandom_range(0, 2) == 0);
      r_im = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFE)
                                         : (32'($urandom_range(0, 64)) - 32'd32) & 32'hFFFF_FFFE;
      r_bs = $urandom;
      halt = ($urandom_range(0, 7) == 0);
      nxt = model_next(cur, r_jr, r_jl, r_b, r_im, r_bs, trp);
      do_exec(r_jr, r_jl, r_b, r_im, r_bs, trp, cur);
      cur = nxt;
      if (halt) begin
        hold = $urandom_range(1, 3);
        for (int h = 0; h < hold; h++) begin
          chk("rnd_halt_req", imem_req, 0);
          chk("rnd_halt_pc", pc, cur);
          imem_ack = 1'($urandom_range(0, 1));
          tick();
        end
        halt = 1'b0;
        imem_ack = 1'b0;
        tick();
      end
    end

    // Reset asserted mid-fetch; a late ack is dropped
    wait_req();
    imem_ack = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", imem_req, 0);
    chk("midrst_addr", imem_addr, 0);
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_pc", pc, RESET_PC);
    chk("midrst_instr", instr, NOP);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("late_ack_instr", instr, NOP);
    chk("late_ack_valid", instr_valid, 0);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    chk("rel_idle_req", imem_req, 0);
    tick();
    fetch(RESET_PC, 1, 32'h0000_0093);
    do_exec(0, 0, 0, 32'h0, 32'h0, 0, RESET_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
